pool_window_feeder: RTL and testbench

Initiator side of the 2x2 pooling engine's start/finish handshake. It buffers one full feature map arriving as a row-major pixel stream and walks it with stride 2. For each window it presents 25 pixels (5x5, origin at the pooling-cell top-left) to the pooling engine, runs the start/finish handshake, and streams the pooled pixels out row-major. It sits between the conv output stream and the Pooling_2x2 engine.

---
 rtl/pool_window_feeder_if.sv | 28 ++
 rtl/pool_window_feeder.sv | 167 ++++++++++++++++
 tb/tb_pool_window_feeder.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_window_feeder_if.sv
// Handshake bundle between the conv pixel stream, the feeder, the 2x2 pooling
// engine and the pooled-pixel consumer. The feeder takes the master view.
interface pool_window_feeder_if #(
  parameter int DATA_W = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic                  pool_start;
  logic [25*DATA_W-1:0]  pool_win;
  logic                  pool_finish;
  logic [DATA_W-1:0]     pool_pixel;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_data;
  logic                  out_last;
  logic                  busy;

  modport master (
    input  in_valid, in_data, pool_finish, pool_pixel, out_ready,
    output in_ready, pool_start, pool_win, out_valid, out_data, out_last, busy
  );

  modport slave (
    output in_valid, in_data, pool_finish, pool_pixel, out_ready,
    input  in_ready, pool_start, pool_win, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/pool_window_feeder.sv
// Buffers one feature map, then walks it with stride 2, presenting a zero-padded
// 5x5 window per pooling cell to the engine and streaming the pooled results out.
module pool_window_feeder #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pool_window_feeder_if.master bus
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int MW   = $clog2(NPIX);
  localparam int AW   = $clog2(NPIX + IMG_W + IMG_H);

  localparam logic [AW-1:0] W_A   = AW'(IMG_W);
  localparam logic [AW-1:0] H_A   = AW'(IMG_H);
  localparam logic [AW-1:0] LASTC = AW'(IMG_W - 2);
  localparam logic [AW-1:0] LASTR = AW'(IMG_H - 2);
  localparam logic [MW-1:0] LAST_ADDR = MW'(NPIX - 1);

  typedef enum logic [2:0] {LOAD, FILL, ISSUE, RELEASE, EMIT} state_t;
  state_t state, next_state;

  logic [DATA_W-1:0] mem [NPIX];
  logic [DATA_W-1:0] win [25];
  logic [MW-1:0]     wr_addr;
  logic              full;
  logic [AW-1:0]     r0, c0;
  logic [2:0]        kr, kc;
  logic [4:0]        k;
  logic              armed;
  logic [DATA_W-1:0] out_q;

  logic              accept, capture, last_win;
  logic [AW-1:0]     row, col;
  logic [MW-1:0]     rd_idx;
  logic [DATA_W-1:0] fill_pix;

  // Source pixel for the current window element; anything past the map edge reads as 0
  assign row      = r0 + AW'(kr);
  assign col      = c0 + AW'(kc);
  assign rd_idx   = MW'(row * W_A + col);
  assign fill_pix = (row < H_A && col < W_A) ? mem[rd_idx] : '0;
  assign last_win = (r0 == LASTR) && (c0 == LASTC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= next_state;
  end

  // The full flag adds one LOAD cycle after the final accept, during which no
  // further pixel is taken before the walk starts
  always_comb begin
    next_state     = state;
    bus.in_ready   = 1'b0;
    bus.pool_start = 1'b0;
    bus.out_valid  = 1'b0;
    bus.busy       = 1'b1;
    accept         = 1'b0;
    capture        = 1'b0;
    case (state)
      LOAD: begin
        bus.busy     = 1'b0;
        bus.in_ready = !full && !rst;
        accept       = bus.in_valid && !full && !rst;
        if (full) next_state = FILL;
      end
      FILL: begin
        if (k == 5'd24) next_state = ISSUE;
      end
      ISSUE: begin
        bus.pool_start = 1'b1;
        if (armed && bus.pool_finish) begin
          capture    = 1'b1;
          next_state = RELEASE;
        end
      end
      RELEASE: begin
        if (!bus.pool_finish) next_state = EMIT;
      end
      EMIT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) next_state = last_win ? LOAD : FILL;
      end
      default: next_state = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_addr] <= bus.in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr <= '0;
      full    <= 1'b0;
      r0      <= '0;
      c0      <= '0;
      kr      <= '0;
      kc      <= '0;
      k       <= '0;
      armed   <= 1'b0;
      out_q   <= '0;
      for (int i = 0; i < 25; i++) win[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (wr_addr == LAST_ADDR) full <= 1'b1;
            else                      wr_addr <= wr_addr + 1'b1;
          end
        end
        FILL: begin
          win[k] <= fill_pix;
          if (k == 5'd24) begin
            k  <= '0;
            kr <= '0;
            kc <= '0;
          end else begin
            k <= k + 5'd1;
            if (kc == 3'd4) begin
              kc <= '0;
              kr <= kr + 3'd1;
            end else begin
              kc <= kc + 3'd1;
            end
          end
        end
        // armed masks a finish left over from the previous window in the first cycle
        ISSUE: begin
          armed <= 1'b1;
          if (capture) begin
            out_q <= bus.pool_pixel;
            armed <= 1'b0;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            if (last_win) begin
              r0      <= '0;
              c0      <= '0;
              wr_addr <= '0;
              full    <= 1'b0;
            end else if (c0 == LASTC) begin
              c0 <= '0;
              r0 <= r0 + AW'(2);
            end else begin
              c0 <= c0 + AW'(2);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.pool_win = '0;
    for (int i = 0; i < 25; i++) bus.pool_win[i*DATA_W +: DATA_W] = win[i];
  end

  assign bus.out_data = out_q;
  assign bus.out_last = (state == EMIT) && last_win;

endmodule

// File: tb/tb_pool_window_feeder.sv
// Directed bench for pool_window_feeder on a 4x4 map, with a behavioural pooling
// engine model and a scoreboard of expected pooled pixels.
module tb_pool_window_feeder;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 16;

  logic clk;
  logic rst;

  pool_window_feeder_if #(.DATA_W(DW)) bus ();

  pool_window_feeder #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] frame [W*H];
  logic [DW-1:0] exp_data [$];
  logic          exp_last [$];

  // Engine model: finish fin_delay cycles after start, held fin_hold cycles after start falls
  int            fin_delay;
  int            fin_hold;
  logic          eng_manual;
  logic          man_fin;
  logic [DW-1:0] man_pix;
  logic          eng_fin;
  logic [DW-1:0] eng_pix;
  int            eng_st;
  int            eng_cnt;

  assign bus.pool_finish = eng_manual ? man_fin : eng_fin;
  assign bus.pool_pixel  = eng_manual ? man_pix : eng_pix;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] engine_avg(input logic [25*DW-1:0] w);
    int s;
    s = int'($signed(w[0*DW +: DW])) + int'($signed(w[1*DW +: DW])) +
        int'($signed(w[5*DW +: DW])) + int'($signed(w[6*DW +: DW]));
    return DW'(s / 4);
  endfunction

  always @(negedge clk) begin
    if (rst || eng_manual) begin
      eng_st  <= 0;
      eng_cnt <= 0;
      eng_fin <= 1'b0;
    end else if (eng_st == 0) begin
      if (bus.pool_start) begin
        if (eng_cnt + 1 >= fin_delay) begin
          eng_fin <= 1'b1;
          eng_pix <= engine_avg(bus.pool_win);
          eng_st  <= 1;
          eng_cnt <= 0;
        end else begin
          eng_cnt <= eng_cnt + 1;
        end
      end
    end else begin
      if (!bus.pool_start) begin
        if (eng_cnt >= fin_hold) begin
          eng_fin <= 1'b0;
          eng_st  <= 0;
          eng_cnt <= 0;
        end else begin
          eng_cnt <= eng_cnt + 1;
        end
      end
    end
  end

  function automatic logic [DW-1:0] model_pix(input int r, input int c);
    if (r < H && c < W) return frame[r*W + c];
    return '0;
  endfunction

  function automatic logic [DW-1:0] model_elem(input int r0, input int c0, input int k);
    return model_pix(r0 + k / 5, c0 + k % 5);
  endfunction

  function automatic logic [DW-1:0] model_avg(input int r0, input int c0);
    int s;
    s = int'($signed(model_pix(r0, c0)))     + int'($signed(model_pix(r0, c0 + 1))) +
        int'($signed(model_pix(r0 + 1, c0))) + int'($signed(model_pix(r0 + 1, c0 + 1)));
    return DW'(s / 4);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic checkWin(input string tag, input logic [25*DW-1:0] obs, input logic [25*DW-1:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_in_ready"},  32'(bus.in_ready),   32'd0);
    checkOutput({tag, "_start"},     32'(bus.pool_start), 32'd0);
    checkWin   ({tag, "_pool_win"},  bus.pool_win,        '0);
    checkOutput({tag, "_out_valid"}, 32'(bus.out_valid),  32'd0);
    checkOutput({tag, "_out_data"},  32'(bus.out_data),   32'd0);
    checkOutput({tag, "_out_last"},  32'(bus.out_last),   32'd0);
    checkOutput({tag, "_busy"},      32'(bus.busy),       32'd0);
  endtask

  // Streams pixels 0..15 and pushes the four pooled results they should produce
  task automatic applyStimulus();
    int n;
    for (int i = 0; i < W*H; i++) frame[i] = DW'(i);
    for (int r = 0; r < H; r += 2)
      for (int c = 0; c < W; c += 2) begin
        exp_data.push_back(model_avg(r, c));
        exp_last.push_back(r == H-2 && c == W-2);
      end
    for (int i = 0; i < W*H; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = frame[i];
      n = 0;
      while (!bus.in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      checkOutput("in_ready_load", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic waitStart();
    int n;
    n = 0;
    while (!bus.pool_start && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("start_seen", 32'(bus.pool_start), 32'd1);
  endtask

  task automatic runWindow(input int r0, input int c0, input int stall, input bit check_timing);
    logic [25*DW-1:0] snap;
    int  n, start_hi, fall_to_emit;
    bit  seen_fin, bad_order;
    waitStart();
    for (int k = 0; k < 25; k++)
      checkOutput($sformatf("win(%0d,%0d)[%0d]", r0, c0, k),
                  32'(bus.pool_win[k*DW +: DW]), 32'(model_elem(r0, c0, k)));
    checkOutput("in_ready_busy", 32'(bus.in_ready), 32'd0);
    checkOutput("busy_issue",    32'(bus.busy),     32'd1);
    snap = bus.pool_win;
    seen_fin = 1'b0; bad_order = 1'b0; start_hi = 0; fall_to_emit = 0; n = 0;
    while (!bus.out_valid && n < 300) begin
      if (bus.pool_finish) seen_fin = 1'b1;
      if (!bus.pool_start && !seen_fin) bad_order = 1'b1;
      if (bus.pool_start) start_hi++;
      else                fall_to_emit++;
      checkWin("win_stable", bus.pool_win, snap);
      @(posedge clk); #1;
      n++;
    end
    checkOutput("emit_reached",    32'(bus.out_valid),   32'd1);
    checkOutput("finish_low_emit", 32'(bus.pool_finish), 32'd0);
    checkOutput("start_until_fin", 32'(bad_order),       32'd0);
    if (check_timing) begin
      checkOutput("start_high_cycles", 32'(start_hi), 32'(fin_delay < 2 ? 2 : fin_delay));
      checkOutput("release_cycles",    32'(fall_to_emit), 32'(fin_hold + 1));
    end
    for (int i = 0; i < stall; i++) begin
      checkOutput("stall_valid", 32'(bus.out_valid),  32'd1);
      checkOutput("stall_data",  32'(bus.out_data),   32'(exp_data.size() != 0 ? exp_data[0] : 16'hxxxx));
      checkOutput("stall_start", 32'(bus.pool_start), 32'd0);
      checkWin   ("stall_win",   bus.pool_win,        snap);
      @(posedge clk); #1;
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    checkOutput("sb_nonempty", 32'(exp_data.size() != 0), 32'd1);
    if (exp_data.size() != 0) begin
      checkOutput($sformatf("out_data(%0d,%0d)", r0, c0), 32'(bus.out_data), 32'(exp_data.pop_front()));
      checkOutput($sformatf("out_last(%0d,%0d)", r0, c0), 32'(bus.out_last), 32'(exp_last.pop_front()));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput("valid_drop", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b0;
    eng_manual   = 1'b0;
    man_fin      = 1'b0;
    man_pix      = '0;
    fin_delay    = 3;
    fin_hold     = 0;

    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 1'b0;
    #1;
    checkOutput("idle_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("idle_busy",     32'(bus.busy),     32'd0);

    // Frame 1: latency, stalled EMIT, slow engine, stale finish, padded last window
    applyStimulus();
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.pool_start && lat < 100);
    checkOutput("start_latency", 32'(lat), 32'd26);
    runWindow(0, 0, 10, 1'b1);

    fin_delay = 7;
    fin_hold  = 4;
    runWindow(0, 2, 0, 1'b1);

    fin_delay  = 3;
    fin_hold   = 0;
    eng_manual = 1'b1;
    man_fin    = 1'b1;
    man_pix    = 16'h7777;
    waitStart();
    @(posedge clk); #1;
    checkOutput("stale_first_cycle", 32'(bus.pool_start), 32'd1);
    @(negedge clk);
    man_fin = 1'b0;
    @(posedge clk); #1;
    checkOutput("stale_second_cycle", 32'(bus.pool_start), 32'd1);
    eng_manual = 1'b0;
    runWindow(2, 0, 0, 1'b0);

    runWindow(2, 2, 0, 1'b1);
    checkOutput("frame_done_busy",     32'(bus.busy),     32'd0);
    checkOutput("frame_done_in_ready", 32'(bus.in_ready), 32'd1);

    // Frame 2: reset lands in the ISSUE of the second window
    applyStimulus();
    runWindow(0, 0, 0, 1'b1);
    waitStart();
    rst = 1'b1;
    #1;
    checkResetOutputs("mid_reset");
    exp_data.delete();
    exp_last.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Frame 3: fresh frame after reset
    applyStimulus();
    runWindow(0, 0, 0, 1'b1);
    runWindow(0, 2, 0, 1'b1);
    runWindow(2, 0, 0, 1'b1);
    runWindow(2, 2, 0, 1'b1);
    checkOutput("final_busy",     32'(bus.busy),          32'd0);
    checkOutput("final_in_ready", 32'(bus.in_ready),      32'd1);
    checkOutput("sb_drained",     32'(exp_data.size()),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
